// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the fetch stage.
package cpu_pkg;

  localparam logic [31:0] NOP_INSN        = 32'h0000_0013;
  localparam int unsigned FETCH_BUF_DEPTH = 2;

  // One fetched instruction as held in the fetch buffer (65 bits).
  typedef struct packed {
    logic        fault;
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry fall-through FIFO for fetched instructions.
// When empty, a push is visible on the head in the same cycle, so a push and
// pop together at count 0 passes the entry straight through without storing it.
// Flush beats push and pop.
module fetch_buf
  import cpu_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t mem_q [FETCH_BUF_DEPTH];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         empty;
  logic         store;
  logic         deq;

  assign empty   = (count_q == 2'd0);
  assign valid_o = !empty || push_i;
  assign count_o = count_q;
  // Pass-through pop consumes the pushed entry; nothing is stored then.
  assign store   = push_i && !(empty && pop_i);
  assign deq     = pop_i && !empty;

  // Head presentation; zero when there is nothing to show.
  always_comb begin
    if (!empty) begin
      head_o = mem_q[rd_ptr_q];
    end else if (push_i) begin
      head_o = push_data_i;
    end else begin
      head_o = '0;
    end
  end

  // Pointer and occupancy next-state.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      rd_ptr_d = rd_ptr_q ^ deq;
      wr_ptr_d = wr_ptr_q ^ store;
      count_d  = count_q + {1'b0, store} - {1'b0, deq};
    end
  end

  // State registers and storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (!flush_i && store) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
    end
  end

`ifndef SYNTHESIS
  // The fetch credit logic must never overfill the buffer.
  push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !flush_i && !pop_i && count_q == 2'(FETCH_BUF_DEPTH)));
`endif

endmodule

// File: rtl/insn_fetch.sv
// Instruction fetch stage: owns the PC, issues ROM reads against buffer
// credit, and delivers instructions to decode over valid/ready.
// Optional INSN_FETCH_MISALIGN_EN: a misaligned redirect target produces one
// fault entry and halts fetch until the next redirect.
module insn_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  output logic [$clog2(MEM_DEPTH)+1:2] rom_addr_o,
  input  logic [31:0]                  rom_rdata_i,
  input  logic                         redirect_i,
  input  logic [31:0]                  redirect_pc_i,
  output logic                         insn_valid_o,
  input  logic                         insn_ready_i,
  output logic [31:0]                  insn_o,
  output logic [31:0]                  insn_pc_o,
  output logic                         insn_fault_o
);

  localparam int unsigned Aw = $clog2(MEM_DEPTH);

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tag_pc_q, tag_pc_d;
  logic         inflight_q, inflight_d;
  logic         halted;
  logic         fault_pend;
  logic [31:0]  fault_pc;
  logic         fault_en;
  logic         pop;
  logic         issue;
  logic [2:0]   occupancy;
  logic         buf_push;
  logic         buf_valid;
  logic [1:0]   buf_count;
  fetch_entry_t buf_push_data;
  fetch_entry_t buf_head;

`ifdef INSN_FETCH_MISALIGN_EN
  logic        halted_q, halted_d;
  logic        fault_pend_q, fault_pend_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic        misalign;

  assign misalign   = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  assign halted     = halted_q;
  assign fault_pend = fault_pend_q;
  assign fault_pc   = fault_pc_q;
  assign fault_en   = 1'b1;

  // Halt and fault-entry bookkeeping; any redirect re-decides both.
  always_comb begin
    halted_d     = halted_q;
    fault_pend_d = misalign;
    fault_pc_d   = fault_pc_q;
    if (redirect_i) begin
      halted_d = misalign;
    end
    if (misalign) begin
      fault_pc_d = redirect_pc_i;
    end
  end

  // Misalign state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      halted_q     <= 1'b0;
      fault_pend_q <= 1'b0;
      fault_pc_q   <= 32'h0;
    end else begin
      halted_q     <= halted_d;
      fault_pend_q <= fault_pend_d;
      fault_pc_q   <= fault_pc_d;
    end
  end
`else
  assign halted     = 1'b0;
  assign fault_pend = 1'b0;
  assign fault_pc   = 32'h0;
  assign fault_en   = 1'b0;
`endif

  assign pop = buf_valid && insn_ready_i;

  // Entries owed or held, less the one leaving this cycle. Pop implies at
  // least one of the added terms is set, so this never underflows.
  assign occupancy = {1'b0, buf_count} + {2'b00, inflight_q} + {2'b00, fault_pend}
                   - {2'b00, pop};
  assign issue     = !redirect_i && !halted && (occupancy < 3'd2);

  // PC advance, redirect, and tagging of the issued address.
  always_comb begin
    pc_d       = pc_q;
    tag_pc_d   = tag_pc_q;
    inflight_d = issue;
    if (redirect_i) begin
      pc_d = redirect_pc_i & ~32'h3;
    end else if (issue) begin
      pc_d     = pc_q + 32'd4;
      tag_pc_d = pc_q;
    end
  end

  // PC and inflight registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q       <= RESET_PC;
      tag_pc_q   <= 32'h0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_pc_q   <= tag_pc_d;
      inflight_q <= inflight_d;
    end
  end

  // A response arriving alongside a redirect is dropped by the flush.
  assign buf_push = inflight_q || fault_pend;

  // Push source: pending fault marker or the ROM response.
  always_comb begin
    if (fault_pend) begin
      buf_push_data = '{fault: 1'b1, pc: fault_pc, insn: NOP_INSN};
    end else begin
      buf_push_data = '{fault: 1'b0, pc: tag_pc_q, insn: rom_rdata_i};
    end
  end

  fetch_buf u_fetch_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (redirect_i),
    .push_i      (buf_push),
    .push_data_i (buf_push_data),
    .pop_i       (pop),
    .valid_o     (buf_valid),
    .head_o      (buf_head),
    .count_o     (buf_count)
  );

  assign rom_addr_o   = pc_q[Aw+1:2];
  assign insn_valid_o = buf_valid;
  assign insn_o       = buf_head.insn;
  assign insn_pc_o    = buf_head.pc;
  assign insn_fault_o = buf_head.fault & fault_en;

endmodule

// File: tb/tb_insn_fetch.sv
// Directed bench for insn_fetch with a behavioural one-cycle-latency ROM.
module tb_insn_fetch;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [9:2]  rom_addr;
  logic [31:0] rom_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        insn_fault;

  logic [31:0] rom [256];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) rom_rdata <= rom[rom_addr];

  insn_fetch #(
    .MEM_DEPTH (256),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rom_addr_o    (rom_addr),
    .rom_rdata_i   (rom_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .insn_valid_o  (insn_valid),
    .insn_ready_i  (insn_ready),
    .insn_o        (insn),
    .insn_pc_o     (insn_pc),
    .insn_fault_o  (insn_fault)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Valid is always checked; payload only when an instruction is expected.
  task automatic check_out(input string tag, input logic v, input logic [31:0] i,
                           input logic [31:0] p, input logic f);
    check_eq({tag, ".valid"}, {31'h0, insn_valid}, {31'h0, v});
    if (v) begin
      check_eq({tag, ".insn"}, insn, i);
      check_eq({tag, ".pc"}, insn_pc, p);
      check_eq({tag, ".fault"}, {31'h0, insn_fault}, {31'h0, f});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = (i + 1) * 32'h11;
    rst_ni      = 1'b0;
    insn_ready  = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    step();
    step();
    check_eq("rst.valid", {31'h0, insn_valid}, 32'h0);
    check_eq("rst.insn", insn, 32'h0);
    check_eq("rst.pc", insn_pc, 32'h0);
    check_eq("rst.fault", {31'h0, insn_fault}, 32'h0);
    check_eq("rst.addr", {24'h0, rom_addr}, 32'h0);

    // Streaming from reset with ready high.
    rst_ni = 1'b1;
    #1;
    check_eq("p1.pre", {31'h0, insn_valid}, 32'h0);
    step();
    check_out("p1.0", 1'b1, 32'h11, 32'h0, 1'b0);
    for (int k = 1; k < 4; k++) begin
      step();
      check_out("p1.seq", 1'b1, (k + 1) * 32'h11, k * 4, 1'b0);
    end

    // Asynchronous reset mid-stream, then back-pressure.
    rst_ni = 1'b0;
    #1;
    check_eq("arst.valid", {31'h0, insn_valid}, 32'h0);
    check_eq("arst.insn", insn, 32'h0);
    check_eq("arst.addr", {24'h0, rom_addr}, 32'h0);
    insn_ready = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
    check_out("p2.first", 1'b1, 32'h11, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      check_out("p2.hold", 1'b1, 32'h11, 32'h0, 1'b0);
    end
    insn_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_out("p2.resume", 1'b1, (k + 1) * 32'h11, k * 4, 1'b0);
    end

    // Fill the buffer, then redirect to 0x40.
    insn_ready = 1'b0;
    step();
    step();
    step();
    check_out("p3.full", 1'b1, 32'h55, 32'h10, 1'b0);
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    check_eq("p3.t1.valid", {31'h0, insn_valid}, 32'h0);
    check_eq("p3.t1.addr", {24'h0, rom_addr}, 32'h10);
    insn_ready = 1'b1;
    step();
    check_out("p3.t2", 1'b1, 32'h121, 32'h40, 1'b0);
    step();
    check_out("p3.t3", 1'b1, 32'h132, 32'h44, 1'b0);

    // Redirect in the same cycle as a pop of pc 0x44.
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    step();
    redirect = 1'b0;
    check_eq("p4.t1.valid", {31'h0, insn_valid}, 32'h0);
    step();
    check_out("p4.t2", 1'b1, 32'h231, 32'h80, 1'b0);
    step();
    check_out("p4.t3", 1'b1, 32'h242, 32'h84, 1'b0);

    // Misaligned redirect target.
    redirect    = 1'b1;
    redirect_pc = 32'h42;
    step();
    redirect = 1'b0;
`ifdef INSN_FETCH_MISALIGN_EN
    check_out("p5.fault", 1'b1, 32'h13, 32'h42, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      check_out("p5.halt", 1'b0, 32'h0, 32'h0, 1'b0);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    step();
    redirect = 1'b0;
    check_eq("p5.r.t1.valid", {31'h0, insn_valid}, 32'h0);
    step();
    check_out("p5.r.t2", 1'b1, 32'h231, 32'h80, 1'b0);
    step();
    check_out("p5.r.t3", 1'b1, 32'h242, 32'h84, 1'b0);
`else
    check_eq("p5.t1.valid", {31'h0, insn_valid}, 32'h0);
    check_eq("p5.t1.addr", {24'h0, rom_addr}, 32'h10);
    step();
    check_out("p5.t2", 1'b1, 32'h121, 32'h40, 1'b0);
    step();
    check_out("p5.t3", 1'b1, 32'h132, 32'h44, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
